bitplane_stream_encoder: RTL and testbench

BITPLANE_STREAM_ENCODER -- requirements
Module: bitplane_stream_encoder

---
 rtl/bitplane_stream_encoder.sv | 122 ++++++++++++
 tb/tb_bitplane_stream_encoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bitplane_stream_encoder.sv
// bitplane_stream_encoder: transposes a captured word vector into bit-planes and packs the non-zero ones.
// Optional feature macro BITPLANE_ENC_STATS_EN adds a saturating stat_planes counter output.
module bitplane_stream_encoder #(
    parameter int WORD_W     = 8,
    parameter int N_WORDS    = 16,
    parameter int GROUP_SIZE = 8,
    parameter int MEM_BW     = 128,
    localparam int N_GROUPS  = N_WORDS / GROUP_SIZE,
    localparam int N_PLANES  = N_GROUPS * WORD_W,
    localparam int NPW       = $clog2(N_PLANES + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_WORDS-1:0][WORD_W-1:0]  to_encode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_PLANES-1:0]             mask,
    output logic [MEM_BW-1:0]               encoded,
    output logic [NPW-1:0]                  n_planes
`ifdef BITPLANE_ENC_STATS_EN
    ,
    output logic [31:0]                     stat_planes
`endif
);
    localparam int BW   = $clog2(WORD_W);
    localparam int GW   = N_GROUPS > 1 ? $clog2(N_GROUPS) : 1;
    localparam int PTRW = $clog2(MEM_BW + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                          state, state_nx;
    logic [N_WORDS-1:0][WORD_W-1:0]  data;
    logic [NPW-1:0]                  plane_cnt;
    logic [GW-1:0]                   grp;
    logic [BW-1:0]                   bit_idx;
    logic [PTRW-1:0]                 ptr_off;
    logic [N_WORDS-1:0]              col;
    logic [GROUP_SIZE-1:0]           plane_lo, plane_rev;
    logic [N_PLANES-1:0]             mask_bit;
    logic [MEM_BW-1:0]               enc_bits;
    logic                            plane_nz, last_plane, accept;

    assign accept     = in_valid && in_ready;
    assign last_plane = plane_cnt == NPW'(N_PLANES - 1);

    // Current plane: bit column of every word, narrowed to the active group, lowest word at the top.
    always_comb begin
        for (int i = 0; i < N_WORDS; i++) col[i] = data[i][bit_idx];
        plane_lo = GROUP_SIZE'(col >> (int'(grp) * GROUP_SIZE));
        for (int k = 0; k < GROUP_SIZE; k++) plane_rev[GROUP_SIZE-1-k] = plane_lo[k];
        plane_nz = |plane_rev;
        mask_bit = N_PLANES'(1) << ((N_GROUPS - 1 - int'(grp)) * WORD_W + int'(bit_idx));
        enc_bits = (MEM_BW'(plane_rev) << (MEM_BW - GROUP_SIZE)) >> ptr_off;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: accept wins, the scan ends on the last plane, results leave on out_ready.
    always_comb begin
        state_nx = accept                         ? SCAN :
                   (state == SCAN && last_plane)  ? DONE :
                   (state == DONE && out_ready)   ? IDLE : state;
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = state == IDLE || (state == DONE && out_ready);
        out_valid = state == DONE;
    end

    // Datapath: capture on accept, then fold one plane per SCAN cycle into the results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data      <= '0;
            mask      <= '0;
            encoded   <= '0;
            n_planes  <= '0;
            ptr_off   <= '0;
            plane_cnt <= '0;
            grp       <= '0;
            bit_idx   <= BW'(WORD_W - 1);
        end else if (accept) begin
            data      <= to_encode;
            mask      <= '0;
            encoded   <= '0;
            n_planes  <= '0;
            ptr_off   <= '0;
            plane_cnt <= '0;
            grp       <= '0;
            bit_idx   <= BW'(WORD_W - 1);
        end else if (state == SCAN) begin
            plane_cnt <= plane_cnt + 1'b1;
            bit_idx   <= bit_idx == '0 ? BW'(WORD_W - 1) : bit_idx - 1'b1;
            grp       <= bit_idx == '0 ? grp + 1'b1 : grp;
            if (plane_nz) begin
                mask     <= mask | mask_bit;
                encoded  <= encoded | enc_bits;
                ptr_off  <= ptr_off + PTRW'(GROUP_SIZE);
                n_planes <= n_planes + 1'b1;
            end
        end
    end

`ifdef BITPLANE_ENC_STATS_EN
    logic [32:0] stat_sum;

    assign stat_sum = {1'b0, stat_planes} + 33'(n_planes);

    // Running total of emitted non-zero planes, pinned at all-ones once it would overflow.
    always_ff @(posedge clk) begin
        if (!rst_n)                      stat_planes <= '0;
        else if (out_valid && out_ready) stat_planes <= stat_sum[32] ? '1 : stat_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_bitplane_stream_encoder.sv
// tb_bitplane_stream_encoder: directed table and corner sequences for bitplane_stream_encoder.
module tb_bitplane_stream_encoder;
    typedef struct {
        logic [15:0][7:0] vec;
        logic [15:0]      mask;
        logic [127:0]     enc;
        logic [4:0]       np;
    } vec_t;

    logic             clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic             in_ready, out_valid;
    logic [15:0][7:0] to_encode = '0;
    logic [15:0]      mask;
    logic [127:0]     encoded;
    logic [4:0]       n_planes;
`ifdef BITPLANE_ENC_STATS_EN
    logic [31:0]      stat_planes;
`endif
    int               checks = 0, failures = 0, lat, exp_stat = 0, seen;
    vec_t             tbl[7];
    logic [15:0][7:0] v;

    always #5 clk = ~clk;

    bitplane_stream_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .to_encode(to_encode), .out_valid(out_valid), .out_ready(out_ready),
        .mask(mask), .encoded(encoded), .n_planes(n_planes)
`ifdef BITPLANE_ENC_STATS_EN
        , .stat_planes(stat_planes)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0][7:0] vv);
        to_encode = vv;
        in_valid  = 1;
        #1 chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        to_encode = {16{8'h5A}};
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 40) begin
            @(posedge clk);
            #1 l++;
        end
        chk("latency", l, 16);
    endtask

    task automatic release_out();
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) tbl[i].vec = '0;
        tbl[0].mask = 16'h0000; tbl[0].enc = '0; tbl[0].np = 0;
        tbl[1].vec[0] = 8'h80;
        tbl[1].mask = 16'h8000; tbl[1].enc = {8'h80, 120'h0}; tbl[1].np = 1;
        tbl[2].vec[8] = 8'h01; tbl[2].vec[15] = 8'h01;
        tbl[2].mask = 16'h0001; tbl[2].enc = {8'h81, 120'h0}; tbl[2].np = 1;
        tbl[3].vec = {16{8'hFF}};
        tbl[3].mask = 16'hFFFF; tbl[3].enc = {128{1'b1}}; tbl[3].np = 16;
        tbl[4].vec[3] = 8'h40;
        tbl[4].mask = 16'h4000; tbl[4].enc = {8'h10, 120'h0}; tbl[4].np = 1;
        tbl[5].vec[0] = 8'h01; tbl[5].vec[9] = 8'h80;
        tbl[5].mask = 16'h0180; tbl[5].enc = {16'h8040, 112'h0}; tbl[5].np = 2;
        tbl[6].vec[2] = 8'h03;
        tbl[6].mask = 16'h0300; tbl[6].enc = {16'h2020, 112'h0}; tbl[6].np = 2;

        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mask", mask, 0);
        chk("rst_encoded", encoded, 0);
        chk("rst_n_planes", n_planes, 0);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].vec);
            wait_done(lat);
            chk("mask", mask, tbl[i].mask);
            chk("encoded", encoded, tbl[i].enc);
            chk("n_planes", n_planes, tbl[i].np);
            release_out();
            exp_stat += tbl[i].np;
        end

        send(tbl[1].vec);
        wait_done(lat);
        repeat (5) begin
            @(posedge clk);
            #1 chk("hold_valid", out_valid, 1);
            chk("hold_mask", mask, 16'h8000);
            chk("hold_encoded", encoded, {8'h80, 120'h0});
            chk("hold_n_planes", n_planes, 1);
        end
        out_ready = 1;
        in_valid  = 1;
        to_encode = {16{8'hFF}};
        #1 chk("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 0;
        in_valid  = 0;
        to_encode = '0;
        exp_stat += 1;
        chk("b2b_scan", out_valid, 0);
        wait_done(lat);
        chk("b2b_mask", mask, 16'hFFFF);
        chk("b2b_n_planes", n_planes, 16);
        release_out();
        exp_stat += 16;
`ifdef BITPLANE_ENC_STATS_EN
        chk("stat_planes", stat_planes, exp_stat);
`endif

        v = {16{8'hFF}};
        send(v);
        repeat (7) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mask", mask, 0);
        chk("midrst_encoded", encoded, 0);
        chk("midrst_n_planes", n_planes, 0);
        chk("midrst_in_ready", in_ready, 1);
`ifdef BITPLANE_ENC_STATS_EN
        chk("midrst_stat", stat_planes, 0);
`endif
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1;
        end
        chk("midrst_no_valid", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
